// File: rtl/c_cmd_pkg.sv
// Shared types for the host-to-RTL command responder: opcodes, response
// status codes and the responder state encoding.
package c_cmd_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_WR   = 3'd1,
    OP_RD   = 3'd2,
    OP_INCR = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_BAD_ADDR = 2'd1,
    ST_BAD_OP   = 2'd2,
    ST_OVERFLOW = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Opcodes 4..7 have no enum member and are rejected as BAD_OP.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || (op == OP_WR) || (op == OP_RD) || (op == OP_INCR);
  endfunction

endpackage

// File: rtl/c_cmd_regfile.sv
// NREGS x DATA_W register file with async clear, one combinational read port,
// one write port, and the increment adder that feeds INCR write-back.
module c_cmd_regfile
  import c_cmd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] add_val,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W:0]   full_sum;
  logic              addr_ok;

  assign addr_ok  = int'(addr) < NREGS;
  assign rd_data  = addr_ok ? regs[addr] : '0;
  assign full_sum = {1'b0, rd_data} + {1'b0, add_val};
  assign sum      = full_sum[DATA_W-1:0];
  assign carry    = full_sum[DATA_W];

  // NOTE: the storage is cleared by reset on purpose -- a reset must wipe every
  // register, including a write committed just before it. Storage that only
  // needs defined contents after a write would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && addr_ok) begin
      regs[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/c_cmd_responder.sv
// Responder for host-issued commands: accepts one request, executes it against
// the register file for one cycle, then holds the response until it is taken.
module c_cmd_responder
  import c_cmd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic [7:0]        txn_count
);

  state_e            state;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] rf_sum;
  logic              rf_carry;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rf_wr_data;

  logic [DATA_W-1:0] exec_data;
  status_e           exec_status;
  logic              exec_wr;
  logic              addr_ok;

  assign req_ready = (state == S_IDLE);
  assign addr_ok   = int'(addr_q) < NREGS;
  assign rf_wr_en  = exec_wr && (state == S_EXEC);

  c_cmd_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr_q),
    .rd_data(rf_rd_data),
    .add_val(data_q),
    .sum    (rf_sum),
    .carry  (rf_carry),
    .wr_en  (rf_wr_en),
    .wr_data(rf_wr_data)
  );

  // NOTE: every output of this block gets a default before the decode so that
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    exec_data   = '0;
    exec_status = ST_OK;
    exec_wr     = 1'b0;
    rf_wr_data  = data_q;
    if (!op_is_legal(op_q)) begin
      exec_status = ST_BAD_OP;
    end else if (op_q == OP_NOP) begin
      exec_status = ST_OK;
    end else if (!addr_ok) begin
      exec_status = ST_BAD_ADDR;
    end else begin
      exec_data = rf_rd_data;
      case (op_q)
        OP_WR: exec_wr = 1'b1;
        OP_INCR: begin
          exec_wr     = 1'b1;
          rf_wr_data  = rf_sum;
          exec_status = rf_carry ? ST_OVERFLOW : ST_OK;
        end
        default: exec_wr = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      txn_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data   <= exec_data;
          rsp_status <= exec_status;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          // Response fields stay frozen until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + 8'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c_cmd_responder.sv
// Directed bench for c_cmd_responder: a table of commands with hand-computed
// responses plus sequences for response stall, mid-command reset and counter wrap.
module tb_c_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [2:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [7:0]  txn_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_txn = 8'd0;

  always #5 clk = ~clk;

  c_cmd_responder #(.DATA_W(32), .ADDR_W(3), .NREGS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_status(rsp_status),
    .txn_count (txn_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  localparam logic [1:0] OK = 2'd0, BADA = 2'd1, BADOP = 2'd2, OVF = 2'd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one command with rsp_ready high; lat counts edges from accept to
  // response handshake inclusive, which is the accept-to-accept spacing.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] addr, input logic [31:0] data,
                        output logic [31:0] d, output logic [1:0] s, output int lat);
    int n = 0;
    req_op = op; req_addr = addr; req_data = data; req_valid = 1'b1;
    while (!req_ready && n < 20) begin step(); n++; end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    d = rsp_data;
    s = rsp_status;
    step();
    lat++;
    exp_txn++;
    check("txn_count", {24'd0, txn_count}, {24'd0, exp_txn});
    check("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;

    vecs[0]  = '{3'd1, 3'd2, 32'h0000_1234, 32'h0,          OK};
    vecs[1]  = '{3'd2, 3'd2, 32'h0,         32'h0000_1234,  OK};
    vecs[2]  = '{3'd2, 3'd7, 32'h0,         32'h0,          BADA};
    vecs[3]  = '{3'd1, 3'd0, 32'hFFFF_FFFE, 32'h0,          OK};
    vecs[4]  = '{3'd3, 3'd0, 32'h3,         32'hFFFF_FFFE,  OVF};
    vecs[5]  = '{3'd2, 3'd0, 32'h0,         32'h0000_0001,  OK};
    vecs[6]  = '{3'd3, 3'd0, 32'h5,         32'h0000_0001,  OK};
    vecs[7]  = '{3'd2, 3'd0, 32'h0,         32'h0000_0006,  OK};
    vecs[8]  = '{3'd0, 3'd7, 32'h55,        32'h0,          OK};
    vecs[9]  = '{3'd1, 3'd6, 32'h5,         32'h0,          BADA};
    vecs[10] = '{3'd2, 3'd2, 32'h0,         32'h0000_1234,  OK};
    vecs[11] = '{3'd5, 3'd1, 32'h9,         32'h0,          BADOP};
    vecs[12] = '{3'd7, 3'd7, 32'h9,         32'h0,          BADOP};
    vecs[13] = '{3'd2, 3'd1, 32'h0,         32'h0,          OK};
    vecs[14] = '{3'd1, 3'd5, 32'h0000_DEAD, 32'h0,          OK};
    vecs[15] = '{3'd2, 3'd5, 32'h0,         32'h0000_DEAD,  OK};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    check("rst_txn_count", {24'd0, txn_count}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, d, s, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_d);
      check($sformatf("vec%0d_status", i), {30'd0, s}, {30'd0, vecs[i].exp_s});
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
    end

    // Stalled BAD_OP response: fields frozen, no accept while stalled.
    rsp_ready = 1'b0;
    req_op = 3'd5; req_addr = 3'd1; req_data = 32'h77; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("stall_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        req_op = 3'd1; req_addr = 3'd1; req_data = 32'h55; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      step();
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_data", rsp_data, 32'd0);
      check("stall_rsp_status", {30'd0, rsp_status}, {30'd0, BADOP});
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    exp_txn++;
    check("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("stall_release_txn", {24'd0, txn_count}, {24'd0, exp_txn});
    check("stall_retain_status", {30'd0, rsp_status}, {30'd0, BADOP});
    do_cmd(3'd2, 3'd1, 32'h0, d, s, lat);
    check("stall_no_write", d, 32'd0);

    // Reset while the WR response is pending: committed write is cleared.
    rsp_ready = 1'b0;
    req_op = 3'd1; req_addr = 3'd3; req_data = 32'hAA; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("rstmid_in_resp", {31'd0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #2;
    check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_txn", {24'd0, txn_count}, 32'd0);
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    exp_txn = 8'd0;
    step();

    // 256 back-to-back NOPs from a zero count wrap the counter to 0.
    for (int k = 0; k < 256; k++) begin
      do_cmd(3'd0, 3'd0, 32'h0, d, s, lat);
      check("nop_latency", lat, 32'd3);
      if (k == 254) check("txn_at_255", {24'd0, txn_count}, 32'd255);
    end
    check("txn_wrapped", {24'd0, txn_count}, 32'd0);

    do_cmd(3'd2, 3'd3, 32'h0, d, s, lat);
    check("rstmid_reg_cleared", d, 32'd0);
    check("rstmid_rd_status", {30'd0, s}, {30'd0, OK});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
